// File: rtl/aes_192_ctr_stream_if.sv
// Data-in / data-out valid/ready streams of the AES-192 CTR sequencer.
// master = source/sink side, slave = sequencer side.
interface aes_192_ctr_stream_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_last;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/aes_192_ctr_stream.sv
// AES-192 CTR-mode block sequencer with an iterative aes_192 core.
// Optional macro AES_CTR_TIMEOUT_EN adds TIMEOUT and a sticky err output.
module aes_192 (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] state,
  input  logic [191:0] key,
  output logic [127:0] out,
  output logic         out_valid
);
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // Inverse as a^254, then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] s, v;
    s = gmul(a, a);
    v = s;
    for (int i = 0; i < 6; i++) begin
      s = gmul(s, s);
      v = gmul(v, s);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] subw(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] round_f(input logic [127:0] s, input logic last);
    logic [7:0]   b [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) b[k] = sbox(s[127-8*k -: 8]);
    for (int c = 0; c < 4; c++) begin
      a0 = b[4*((c+0)%4)+0];
      a1 = b[4*((c+1)%4)+1];
      a2 = b[4*((c+2)%4)+2];
      a3 = b[4*((c+3)%4)+3];
      if (last)
        o[127-32*c -: 32] = {a0, a1, a2, a3};
      else
        o[127-32*c -: 32] = {xt(a0)^xt(a1)^a1^a2^a3,
                             a0^xt(a1)^xt(a2)^a2^a3,
                             a0^a1^xt(a2)^xt(a3)^a3,
                             xt(a0)^a0^a1^a2^xt(a3)};
    end
    return o;
  endfunction

  logic [127:0]      st_q, st_n, base;
  logic [5:0][31:0]  win_q, win_ld;
  logic [31:0]       tmp, w_n;
  logic [5:0]        j_q;
  logic [2:0]        p6_q;
  logic [7:0]        rcon_q;
  logic              run_q, start_d;

  // One round-key word per cycle; a full round every fourth word.
  always_comb begin
    base = st_q;
    if (j_q[1:0] == 2'd0 && j_q != 6'd0) base = round_f(st_q, j_q == 6'd48);
    st_n = base ^ ({win_q[0], 96'h0} >> {j_q[1:0], 5'd0});
    tmp = win_q[5];
    if (p6_q == 3'd0)
      tmp = subw({win_q[5][23:0], win_q[5][31:24]}) ^ {rcon_q, 24'h0};
    w_n = win_q[0] ^ tmp;
    for (int k = 0; k < 6; k++) win_ld[k] = key[191-32*k -: 32];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q      <= '0;
      win_q     <= '0;
      j_q       <= '0;
      p6_q      <= '0;
      rcon_q    <= '0;
      run_q     <= 1'b0;
      start_d   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      start_d <= start;
      if (!start) begin
        run_q     <= 1'b0;
        out_valid <= 1'b0;
      end else if (!start_d) begin
        st_q      <= state;
        win_q     <= win_ld;
        j_q       <= '0;
        p6_q      <= '0;
        rcon_q    <= 8'h01;
        run_q     <= 1'b1;
        out_valid <= 1'b0;
      end else if (run_q) begin
        st_q  <= st_n;
        win_q <= {w_n, win_q[5:1]};
        p6_q  <= (p6_q == 3'd5) ? 3'd0 : p6_q + 3'd1;
        if (p6_q == 3'd0) rcon_q <= xt(rcon_q);
        j_q <= j_q + 6'd1;
        if (j_q == 6'd51) begin
          run_q     <= 1'b0;
          out_valid <= 1'b1;
        end
      end
    end
  end

  assign out = st_q;
endmodule

module aes_192_ctr_stream #(
  parameter int CTR_WIDTH   = 32,
  parameter int START_GUARD = 2
`ifdef AES_CTR_TIMEOUT_EN
  , parameter int TIMEOUT   = 1024
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 init,
  input  logic [127:0]         iv,
  input  logic [191:0]         key,
  aes_192_ctr_stream_if.slave  bus,
  output logic                 busy,
  output logic                 ctr_wrap
`ifdef AES_CTR_TIMEOUT_EN
  , output logic               err
`endif
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ARM  = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] OUT  = 2'd3;

  localparam logic [127:0] MASK = (128'd1 << CTR_WIDTH) - 128'd1;
  localparam logic [15:0]  GMAX = 16'(START_GUARD);

  logic [1:0]   state_q;
  logic [127:0] ctr_q, data_q, od_q, core_out, ctr_inc;
  logic [191:0] key_q;
  logic [15:0]  guard_q;
  logic         last_q, ol_q, ov_q, core_start, core_valid;
`ifdef AES_CTR_TIMEOUT_EN
  logic [31:0]  tmo_q;
`endif

  aes_192 u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (core_start),
    .state     (ctr_q),
    .key       (key_q),
    .out       (core_out),
    .out_valid (core_valid)
  );

  assign ctr_inc = (ctr_q & ~MASK) | ((ctr_q + 128'd1) & MASK);

  assign bus.in_ready  = (state_q == IDLE) && !init && !rst;
  assign bus.out_valid = ov_q;
  assign bus.out_data  = od_q;
  assign bus.out_last  = ol_q;
  assign busy          = (state_q != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      ctr_q      <= '0;
      key_q      <= '0;
      data_q     <= '0;
      last_q     <= 1'b0;
      od_q       <= '0;
      ol_q       <= 1'b0;
      ov_q       <= 1'b0;
      ctr_wrap   <= 1'b0;
      core_start <= 1'b0;
      guard_q    <= '0;
`ifdef AES_CTR_TIMEOUT_EN
      tmo_q      <= '0;
      err        <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (init) begin
            ctr_q    <= iv;
            key_q    <= key;
            ctr_wrap <= 1'b0;
`ifdef AES_CTR_TIMEOUT_EN
            err      <= 1'b0;
`endif
          end else if (bus.in_valid) begin
            data_q  <= bus.in_data;
            last_q  <= bus.in_last;
            state_q <= ARM;
          end
        end
        ARM: begin
          core_start <= 1'b1;
          guard_q    <= '0;
`ifdef AES_CTR_TIMEOUT_EN
          tmo_q      <= '0;
`endif
          state_q    <= RUN;
        end
        RUN: begin
          if (guard_q != GMAX) guard_q <= guard_q + 16'd1;
          if (guard_q == GMAX && core_valid) begin
            od_q       <= data_q ^ core_out;
            ol_q       <= last_q;
            ov_q       <= 1'b1;
            core_start <= 1'b0;
            state_q    <= OUT;
          end
`ifdef AES_CTR_TIMEOUT_EN
          else if (tmo_q == 32'(TIMEOUT - 1)) begin
            err        <= 1'b1;
            core_start <= 1'b0;
            state_q    <= IDLE;
          end else begin
            tmo_q <= tmo_q + 32'd1;
          end
`endif
        end
        OUT: begin
          if (bus.out_ready) begin
            ov_q    <= 1'b0;
            ctr_q   <= ctr_inc;
            if ((ctr_q & MASK) == MASK) ctr_wrap <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
